layer_scheduler: RTL

- Sequences the neuron accumulation controller through a full network pass: up to NUM_LAYERS layers, each with a programmable input count and neuron count.
- Issues one neuron at a time to the controller, loads its cycle counter via DB/DD, and tracks weight and bias base addresses.
- Waits for each neuron's output-done pulse before issuing the next neuron.
- Sits between the top-level host/config interface and the per-neuron controller.

---
 rtl/layer_scheduler_pkg.sv | 28 ++
 rtl/layer_scheduler_if.sv | 42 ++++
 rtl/layer_cfg_regs.sv | 52 +++++
 rtl/layer_scheduler.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/layer_scheduler_pkg.sv
// Shared definitions for the layer scheduler slice.
// - Default values for the scheduler parameters.
// - 3-bit state encoding constants and the FSM state type built on them.
package layer_scheduler_pkg;

    localparam int DEF_NUM_LAYERS = 3;
    localparam int DEF_ADDR_W     = 16;
    localparam int DEF_WDOG_MAX   = 1023;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CFG    = 3'd1;
    localparam logic [2:0] ST_SETTLE = 3'd2;
    localparam logic [2:0] ST_ISSUE  = 3'd3;
    localparam logic [2:0] ST_WAIT   = 3'd4;
    localparam logic [2:0] ST_ADV    = 3'd5;
    localparam logic [2:0] ST_FIN    = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_CFG    = ST_CFG,
        S_SETTLE = ST_SETTLE,
        S_ISSUE  = ST_ISSUE,
        S_WAIT   = ST_WAIT,
        S_ADV    = ST_ADV,
        S_FIN    = ST_FIN
    } state_t;

endpackage

// File: rtl/layer_scheduler_if.sv
// Host/config and neuron-controller signals of the layer scheduler.
// master : host + controller side (drives commands, config, neuron done)
// slave  : the scheduler (drives controller strobes, addresses, status)
interface layer_scheduler_if #(
    parameter int ADDR_W = layer_scheduler_pkg::DEF_ADDR_W
);
    // host / config
    logic              start;
    logic              abort;
    logic              cfg_we;
    logic [1:0]        cfg_idx;
    logic [15:0]       cfg_nin;
    logic [7:0]        cfg_nout;
    // from neuron controller
    logic              neur_done;
    // to neuron controller
    logic              en_fsm;
    logic              ctrl_rst;
    logic [7:0]        db;
    logic [7:0]        dd;
    logic [ADDR_W-1:0] w_base;
    logic [ADDR_W-1:0] b_addr;
    // status
    logic [1:0]        layer;
    logic [7:0]        neuron;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output start, abort, cfg_we, cfg_idx, cfg_nin, cfg_nout, neur_done,
        input  en_fsm, ctrl_rst, db, dd, w_base, b_addr, layer, neuron,
               busy, done, err
    );

    modport slave (
        input  start, abort, cfg_we, cfg_idx, cfg_nin, cfg_nout, neur_done,
        output en_fsm, ctrl_rst, db, dd, w_base, b_addr, layer, neuron,
               busy, done, err
    );

endinterface

// File: rtl/layer_cfg_regs.sv
// Per-layer configuration slots (inputs per neuron, neurons per layer).
// Ports:
//   clk, rst          clock, asynchronous active-high reset (slots -> 0)
//   we                write strobe, already gated by the caller
//   wr_idx/nin/nout   slot index and contents; indices past NUM_LAYERS drop
//   rd_idx            slot to read
//   rd_nin, rd_nout   combinational read of slot rd_idx
module layer_cfg_regs import layer_scheduler_pkg::*; #(
    parameter int NUM_LAYERS = DEF_NUM_LAYERS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [1:0]  wr_idx,
    input  logic [15:0] wr_nin,
    input  logic [7:0]  wr_nout,
    input  logic [1:0]  rd_idx,
    output logic [15:0] rd_nin,
    output logic [7:0]  rd_nout
);

    logic [15:0] nin_reg  [NUM_LAYERS];
    logic [7:0]  nout_reg [NUM_LAYERS];

    // One register pair per slot; a write whose index matches no slot is
    // simply not captured anywhere.
    generate
        for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_slot
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    nin_reg[gi]  <= '0;
                    nout_reg[gi] <= '0;
                end else if (we && (wr_idx == 2'(gi))) begin
                    nin_reg[gi]  <= wr_nin;
                    nout_reg[gi] <= wr_nout;
                end
            end
        end
    endgenerate

    always_comb begin
        rd_nin  = '0;
        rd_nout = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (rd_idx == 2'(i)) begin
                rd_nin  = nin_reg[i];
                rd_nout = nout_reg[i];
            end
        end
    end

endmodule

// File: rtl/layer_scheduler.sv
// Layer scheduler: walks the neuron controller through every neuron of
// every configured layer, one neuron at a time.
// Ports:
//   CLKEXT  system clock
//   RST     asynchronous active-high reset
//   bus     layer_scheduler_if.slave: START/ABORT, config writes, NEUR_DONE
//           in; EN_FSM, CTRL_RST, DB/DD, W_BASE, B_ADDR, LAYER, NEURON,
//           BUSY, DONE, ERR out. Every output comes straight from a register.
module layer_scheduler import layer_scheduler_pkg::*; #(
    parameter int NUM_LAYERS = DEF_NUM_LAYERS,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int WDOG_MAX   = DEF_WDOG_MAX
) (
    input logic         CLKEXT,
    input logic         RST,
    layer_scheduler_if.slave bus
);

    localparam int              WDOG_W     = $clog2(WDOG_MAX + 1);
    // Counter value in the last permitted WAIT cycle: it would reach
    // WDOG_MAX on the following edge.
    localparam logic [WDOG_W-1:0] WDOG_LAST  = WDOG_W'(WDOG_MAX - 1);
    localparam logic [1:0]        LAST_LAYER = 2'(NUM_LAYERS - 1);

    state_t              state_reg,    state_next;
    logic [1:0]          layer_reg,    layer_next;
    logic [7:0]          neuron_reg,   neuron_next;
    logic [ADDR_W-1:0]   w_base_reg,   w_base_next;
    logic [ADDR_W-1:0]   b_addr_reg,   b_addr_next;
    logic [7:0]          db_reg,       db_next;
    logic [7:0]          dd_reg,       dd_next;
    logic [WDOG_W-1:0]   wdog_reg,     wdog_next;
    logic                en_fsm_reg,   en_fsm_next;
    logic                ctrl_rst_reg, ctrl_rst_next;
    logic                busy_reg,     busy_next;
    logic                done_reg,     done_next;
    logic                err_reg,      err_next;

    logic                cfg_wr;
    logic [15:0]         cur_nin;
    logic [7:0]          cur_nout;
    logic [ADDR_W-1:0]   nin_ext;

    layer_cfg_regs #(
        .NUM_LAYERS (NUM_LAYERS)
    ) u_cfg (
        .clk     (CLKEXT),
        .rst     (RST),
        .we      (cfg_wr),
        .wr_idx  (bus.cfg_idx),
        .wr_nin  (bus.cfg_nin),
        .wr_nout (bus.cfg_nout),
        .rd_idx  (layer_reg),
        .rd_nin  (cur_nin),
        .rd_nout (cur_nout)
    );

    // Weight stride: zero-extend or truncate NIN to the address width.
    assign nin_ext = ADDR_W'(cur_nin);

    always_ff @(posedge CLKEXT or posedge RST) begin
        if (RST) begin
            state_reg    <= S_IDLE;
            layer_reg    <= '0;
            neuron_reg   <= '0;
            w_base_reg   <= '0;
            b_addr_reg   <= '0;
            db_reg       <= '0;
            dd_reg       <= '0;
            wdog_reg     <= '0;
            en_fsm_reg   <= 1'b0;
            ctrl_rst_reg <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            layer_reg    <= layer_next;
            neuron_reg   <= neuron_next;
            w_base_reg   <= w_base_next;
            b_addr_reg   <= b_addr_next;
            db_reg       <= db_next;
            dd_reg       <= dd_next;
            wdog_reg     <= wdog_next;
            en_fsm_reg   <= en_fsm_next;
            ctrl_rst_reg <= ctrl_rst_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
            err_reg      <= err_next;
        end
    end

    // Strobe outputs are computed for the state being entered, so EN_FSM is
    // high exactly while in ISSUE and DONE exactly while in FIN. CTRL_RST
    // from CFG lands in SETTLE, together with the freshly loaded DB/DD.
    always_comb begin
        state_next    = state_reg;
        layer_next    = layer_reg;
        neuron_next   = neuron_reg;
        w_base_next   = w_base_reg;
        b_addr_next   = b_addr_reg;
        db_next       = db_reg;
        dd_next       = dd_reg;
        wdog_next     = wdog_reg;
        err_next      = err_reg;
        en_fsm_next   = 1'b0;
        ctrl_rst_next = 1'b0;
        done_next     = 1'b0;
        cfg_wr        = 1'b0;

        if ((state_reg != S_IDLE) && bus.abort) begin
            // Abort beats NEUR_DONE and the watchdog.
            state_next    = S_IDLE;
            ctrl_rst_next = 1'b1;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    cfg_wr = bus.cfg_we;
                    if (bus.start) begin
                        err_next    = 1'b0;
                        layer_next  = '0;
                        neuron_next = '0;
                        w_base_next = '0;
                        b_addr_next = '0;
                        state_next  = S_CFG;
                    end
                end
                S_CFG: begin
                    db_next = cur_nin[15:8];
                    dd_next = cur_nin[7:0];
                    if ((cur_nin == 16'd0) || (cur_nout == 8'd0)) begin
                        err_next   = 1'b1;
                        state_next = S_IDLE;
                    end else begin
                        ctrl_rst_next = 1'b1;
                        state_next    = S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    en_fsm_next = 1'b1;
                    state_next  = S_ISSUE;
                end
                S_ISSUE: begin
                    wdog_next  = '0;
                    state_next = S_WAIT;
                end
                S_WAIT: begin
                    wdog_next = wdog_reg + 1'b1;
                    if (bus.neur_done) begin
                        // Done wins even in the watchdog's last cycle.
                        state_next = S_ADV;
                    end else if (wdog_reg == WDOG_LAST) begin
                        err_next      = 1'b1;
                        ctrl_rst_next = 1'b1;
                        state_next    = S_IDLE;
                    end
                end
                S_ADV: begin
                    w_base_next = w_base_reg + nin_ext;
                    b_addr_next = b_addr_reg + 1'b1;
                    if (({1'b0, neuron_reg} + 9'd1) < {1'b0, cur_nout}) begin
                        neuron_next = neuron_reg + 8'd1;
                        en_fsm_next = 1'b1;
                        state_next  = S_ISSUE;
                    end else if (layer_reg != LAST_LAYER) begin
                        layer_next  = layer_reg + 2'd1;
                        neuron_next = '0;
                        state_next  = S_CFG;
                    end else begin
                        done_next  = 1'b1;
                        state_next = S_FIN;
                    end
                end
                S_FIN: begin
                    state_next = S_IDLE;
                end
                default: begin
                    state_next = S_IDLE;
                end
            endcase
        end

        busy_next = (state_next != S_IDLE);
    end

    assign bus.en_fsm   = en_fsm_reg;
    assign bus.ctrl_rst = ctrl_rst_reg;
    assign bus.db       = db_reg;
    assign bus.dd       = dd_reg;
    assign bus.w_base   = w_base_reg;
    assign bus.b_addr   = b_addr_reg;
    assign bus.layer    = layer_reg;
    assign bus.neuron   = neuron_reg;
    assign bus.busy     = busy_reg;
    assign bus.done     = done_reg;
    assign bus.err      = err_reg;

endmodule
